// File: rtl/mesi_req_sched.sv
// Request scheduler and MESI line-state store for the L2 controller.
// Arbitrates L1 and snoop requests, runs one request at a time through the
// external per-line MESI FSM (LOAD -> EXEC -> WB), and writes the result back.
module mesi_req_sched #(
  parameter int                 IDX_W    = 4,
  parameter int                 MSG_W    = 4,
  parameter logic [MSG_W-1:0]   IDLE_MSG = 4'hF,
  parameter logic [1:0]         ST_I     = 2'b00,
  parameter int                 SNP_MAX  = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             l1_req_valid,
  input  logic [MSG_W-1:0] l1_req_cmd,
  input  logic [IDX_W-1:0] l1_req_idx,
  output logic             l1_req_ready,
  input  logic             snp_req_valid,
  input  logic [MSG_W-1:0] snp_req_cmd,
  input  logic [IDX_W-1:0] snp_req_idx,
  output logic             snp_req_ready,
  output logic             fsm_valid,
  output logic             fsm_valid_d,
  output logic [MSG_W-1:0] fsm_nmsg,
  output logic [1:0]       fsm_state_in,
  input  logic [1:0]       fsm_state_out,
  output logic             rsp_valid,
  output logic             rsp_src,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [1:0]       rsp_state,
  output logic             busy
);

  localparam int                 DEPTH   = 1 << IDX_W;
  localparam int                 STK_W   = $clog2(SNP_MAX + 1);
  localparam logic [STK_W-1:0]   STK_MAX = STK_W'(SNP_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic [MSG_W-1:0]   cmd_q;
  logic [IDX_W-1:0]   idx_q;
  logic               src_q;
  logic               fsm_valid_q;
  logic               fsm_valid_d_q;
  logic [MSG_W-1:0]   nmsg_q;
  logic [1:0]         state_in_q;
  logic               rsp_valid_q;
  logic [1:0]         table_q [DEPTH];

  logic               snp_grant;
  logic               l1_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [MSG_W-1:0]   grant_cmd;

  // Arbitration in IDLE: snoops win unless they have starved a waiting L1 request.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    snp_grant = 1'b0;
    l1_grant  = 1'b0;
    if (state_q == S_IDLE) begin
      snp_grant = snp_req_valid && (!l1_req_valid || (streak_q < STK_MAX));
      l1_grant  = l1_req_valid && !snp_grant;
    end
    grant_idx = snp_grant ? snp_req_idx : l1_req_idx;
    grant_cmd = snp_grant ? snp_req_cmd : l1_req_cmd;
  end

  // Next-state for the sequencer and the saturating snoop streak counter.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      S_IDLE: if (snp_grant || l1_grant) state_d = S_LOAD;
      S_LOAD: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (l1_grant) begin
      streak_d = '0;
    end else if (snp_grant && (streak_q != STK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Sequencer state, captured request, and registered FSM strobes/outputs.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!rstb) begin
      state_q       <= S_IDLE;
      streak_q      <= '0;
      cmd_q         <= '0;
      idx_q         <= '0;
      src_q         <= 1'b0;
      fsm_valid_q   <= 1'b0;
      fsm_valid_d_q <= 1'b0;
      nmsg_q        <= IDLE_MSG;
      state_in_q    <= ST_I;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (snp_grant || l1_grant) begin
        cmd_q <= grant_cmd;
        idx_q <= grant_idx;
        src_q <= snp_grant;
      end
      // Table read at grant time is safe: the previous WB has already written it.
      fsm_valid_q   <= (state_d == S_LOAD);
      state_in_q    <= (state_d == S_LOAD) ? table_q[grant_idx] : ST_I;
      fsm_valid_d_q <= (state_d == S_EXEC);
      nmsg_q        <= (state_d == S_EXEC) ? cmd_q : IDLE_MSG;
      rsp_valid_q   <= (state_d == S_WB);
    end
  end

  // Line-state table: written only in WB with the FSM's resolved state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: this table is deliberately built from resettable flops so every line starts Invalid;
      // a RAM macro could not be cleared this way.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= ST_I;
      end
    end else if (state_q == S_WB) begin
      table_q[idx_q] <= fsm_state_out;
    end
  end

  assign l1_req_ready  = l1_grant;
  assign snp_req_ready = snp_grant;
  assign fsm_valid     = fsm_valid_q;
  assign fsm_valid_d   = fsm_valid_d_q;
  assign fsm_nmsg      = nmsg_q;
  assign fsm_state_in  = state_in_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_src       = rsp_valid_q & src_q;
  assign rsp_idx       = rsp_valid_q ? idx_q : '0;
  assign rsp_state     = rsp_valid_q ? fsm_state_out : ST_I;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mesi_req_sched.sv
// Directed bench for mesi_req_sched; the bench plays the role of the MESI FSM
// by driving fsm_state_out with the state it wants written back.
module tb_mesi_req_sched;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [3:0] READ_D    = 4'h0;
  localparam logic [3:0] READ_I    = 4'h1;
  localparam logic [3:0] WRITE_D   = 4'h2;
  localparam logic [3:0] SNP_INVAL = 4'h6;
  localparam logic [3:0] IDLE_MSG  = 4'hF;

  logic       clk;
  logic       rstb;
  logic       l1_req_valid;
  logic [3:0] l1_req_cmd;
  logic [3:0] l1_req_idx;
  logic       l1_req_ready;
  logic       snp_req_valid;
  logic [3:0] snp_req_cmd;
  logic [3:0] snp_req_idx;
  logic       snp_req_ready;
  logic       fsm_valid;
  logic       fsm_valid_d;
  logic [3:0] fsm_nmsg;
  logic [1:0] fsm_state_in;
  logic [1:0] fsm_state_out;
  logic       rsp_valid;
  logic       rsp_src;
  logic [3:0] rsp_idx;
  logic [1:0] rsp_state;
  logic       busy;

  int checks;
  int failures;

  mesi_req_sched #(
    .IDX_W(4), .MSG_W(4), .IDLE_MSG(4'hF), .ST_I(2'b00), .SNP_MAX(3)
  ) dut (
    .clk(clk), .rstb(rstb),
    .l1_req_valid(l1_req_valid), .l1_req_cmd(l1_req_cmd), .l1_req_idx(l1_req_idx),
    .l1_req_ready(l1_req_ready),
    .snp_req_valid(snp_req_valid), .snp_req_cmd(snp_req_cmd), .snp_req_idx(snp_req_idx),
    .snp_req_ready(snp_req_ready),
    .fsm_valid(fsm_valid), .fsm_valid_d(fsm_valid_d), .fsm_nmsg(fsm_nmsg),
    .fsm_state_in(fsm_state_in), .fsm_state_out(fsm_state_out),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_idx(rsp_idx), .rsp_state(rsp_state),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from IDLE to the following IDLE and reports what was seen.
  task automatic issue(input bit is_snp, input logic [3:0] cmd, input logic [3:0] idx,
                       input logic [1:0] ret, output bit ok, output logic [1:0] ld,
                       output bit rv, output logic rsrc, output logic [3:0] ridx,
                       output logic [1:0] rst_o);
    ok = 1'b0; ld = 2'bxx; rv = 1'b0; rsrc = 1'bx; ridx = 4'hx; rst_o = 2'bxx;
    fsm_state_out = ret;
    if (is_snp) begin
      snp_req_valid = 1'b1; snp_req_cmd = cmd; snp_req_idx = idx;
    end else begin
      l1_req_valid = 1'b1; l1_req_cmd = cmd; l1_req_idx = idx;
    end
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (is_snp ? snp_req_ready : l1_req_ready) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      snp_req_valid = 1'b0; l1_req_valid = 1'b0;
      return;
    end
    step();
    snp_req_valid = 1'b0; l1_req_valid = 1'b0;
    ld = fsm_state_in;
    step();
    step();
    rv = rsp_valid; rsrc = rsp_src; ridx = rsp_idx; rst_o = rsp_state;
    step();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    l1_req_valid = 1'b0; l1_req_cmd = '0; l1_req_idx = '0;
    snp_req_valid = 1'b0; snp_req_cmd = '0; snp_req_idx = '0;
    fsm_state_out = ST_I;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, fsm_valid, fsm_valid_d, rsp_valid, rsp_src} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, fsm_valid, fsm_valid_d, rsp_valid, rsp_src});
    end
    checks++;
    if (fsm_nmsg !== IDLE_MSG || fsm_state_in !== ST_I || rsp_idx !== 4'h0 || rsp_state !== ST_I) begin
      failures++;
      $display("FAIL reset_data: nmsg=%h state_in=%h rsp_idx=%h rsp_state=%h expected f 0 0 0",
               fsm_nmsg, fsm_state_in, rsp_idx, rsp_state);
    end
    checks++;
    if (l1_req_ready !== 1'b0 || snp_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got l1=%b snp=%b expected 0 0", l1_req_ready, snp_req_ready);
    end
    rstb = 1'b1;
    step();
  endtask

  task automatic test_l1_basic();
    bit ok; logic [1:0] ld; bit rv; logic rsrc; logic [3:0] ridx; logic [1:0] rst_o;
    // Cycle T: grant
    fsm_state_out = ST_E;
    l1_req_valid = 1'b1; l1_req_cmd = READ_D; l1_req_idx = 4'd5;
    #1;
    checks++;
    if (l1_req_ready !== 1'b1 || snp_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL l1_grant_T: got l1=%b snp=%b expected 1 0", l1_req_ready, snp_req_ready);
    end
    step();  // T+1 LOAD
    l1_req_valid = 1'b0;
    checks++;
    if (fsm_valid !== 1'b1 || fsm_valid_d !== 1'b0 || fsm_state_in !== ST_I || busy !== 1'b1) begin
      failures++;
      $display("FAIL l1_load_T1: got valid=%b valid_d=%b state_in=%h busy=%b expected 1 0 0 1",
               fsm_valid, fsm_valid_d, fsm_state_in, busy);
    end
    step();  // T+2 EXEC
    checks++;
    if (fsm_nmsg !== READ_D || fsm_valid_d !== 1'b1 || fsm_valid !== 1'b0 || fsm_state_in !== ST_I) begin
      failures++;
      $display("FAIL l1_exec_T2: got nmsg=%h valid_d=%b valid=%b state_in=%h expected 0 1 0 0",
               fsm_nmsg, fsm_valid_d, fsm_valid, fsm_state_in);
    end
    step();  // T+3 WB
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 1'b0 || rsp_idx !== 4'd5 || rsp_state !== ST_E ||
        fsm_nmsg !== IDLE_MSG) begin
      failures++;
      $display("FAIL l1_wb_T3: got rv=%b src=%b idx=%h st=%h nmsg=%h expected 1 0 5 2 f",
               rsp_valid, rsp_src, rsp_idx, rsp_state, fsm_nmsg);
    end
    step();  // T+4 IDLE
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL l1_idle_T4: got rv=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    // Back-to-back to the same index sees the written-back E.
    issue(1'b0, WRITE_D, 4'd5, ST_M, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_E || !rv || rst_o !== ST_M) begin
      failures++;
      $display("FAIL l1_same_idx: got ok=%b load=%h rv=%b st=%h expected 1 2 1 3", ok, ld, rv, rst_o);
    end
  endtask

  task automatic test_snoop_inval();
    bit ok; logic [1:0] ld; bit rv; logic rsrc; logic [3:0] ridx; logic [1:0] rst_o;
    issue(1'b0, READ_I, 4'd3, ST_S, ok, ld, rv, rsrc, ridx, rst_o);  // line 3 -> S
    issue(1'b1, SNP_INVAL, 4'd3, ST_I, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_S || !rv || rsrc !== 1'b1 || ridx !== 4'd3 || rst_o !== ST_I) begin
      failures++;
      $display("FAIL snoop_inval: got ok=%b load=%h rv=%b src=%b idx=%h st=%h expected 1 1 1 1 3 0",
               ok, ld, rv, rsrc, ridx, rst_o);
    end
    issue(1'b0, READ_D, 4'd3, ST_E, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_I) begin
      failures++;
      $display("FAIL snoop_table3: got ok=%b load=%h expected 1 0", ok, ld);
    end
  endtask

  task automatic test_arbitration();
    // Streak is 0 here: the previous grant was an L1 request.
    logic [7:0] exp_snp;
    exp_snp = 8'b0111_0111;  // bit g = snoop expected at grant g (LSB first): S,S,S,L1,...
    fsm_state_out = ST_S;
    l1_req_valid = 1'b1; l1_req_cmd = READ_D; l1_req_idx = 4'd9;
    snp_req_valid = 1'b1; snp_req_cmd = SNP_INVAL; snp_req_idx = 4'd10;
    for (int g = 0; g < 8; g++) begin
      #1;
      checks++;
      if (snp_req_ready !== exp_snp[g] || l1_req_ready !== !exp_snp[g]) begin
        failures++;
        $display("FAIL arb_grant%0d: got snp=%b l1=%b expected %b %b",
                 g, snp_req_ready, l1_req_ready, exp_snp[g], !exp_snp[g]);
      end
      repeat (4) step();
    end
    l1_req_valid = 1'b0; snp_req_valid = 1'b0;
  endtask

  task automatic test_snoop_only();
    bit ok; logic [1:0] ld; bit rv; logic rsrc; logic [3:0] ridx; logic [1:0] rst_o;
    int granted;
    granted = 0;
    for (int n = 0; n < 6; n++) begin
      issue(1'b1, SNP_INVAL, 4'(n), ST_I, ok, ld, rv, rsrc, ridx, rst_o);
      if (ok && rv && rsrc === 1'b1 && ridx === 4'(n)) granted++;
    end
    checks++;
    if (granted !== 6) begin
      failures++;
      $display("FAIL snoop_only_count: got %0d expected 6", granted);
    end
    // Streak saturated at 3: with both pending, L1 must win now.
    l1_req_valid = 1'b1; l1_req_cmd = READ_D; l1_req_idx = 4'd1;
    snp_req_valid = 1'b1; snp_req_cmd = SNP_INVAL; snp_req_idx = 4'd2;
    #1;
    checks++;
    if (l1_req_ready !== 1'b1 || snp_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL snoop_streak_sat: got l1=%b snp=%b expected 1 0", l1_req_ready, snp_req_ready);
    end
    step();
    l1_req_valid = 1'b0; snp_req_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_index_wrap();
    bit ok; logic [1:0] ld; bit rv; logic rsrc; logic [3:0] ridx; logic [1:0] rst_o;
    issue(1'b0, WRITE_D, 4'd15, ST_M, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ridx !== 4'd15 || rst_o !== ST_M) begin
      failures++;
      $display("FAIL wrap_15: got ok=%b idx=%h st=%h expected 1 f 3", ok, ridx, rst_o);
    end
    issue(1'b0, READ_D, 4'd0, ST_E, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_I) begin
      failures++;
      $display("FAIL wrap_alias0: got ok=%b load=%h expected 1 0", ok, ld);
    end
    issue(1'b0, READ_D, 4'd15, ST_M, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_M) begin
      failures++;
      $display("FAIL wrap_reload15: got ok=%b load=%h expected 1 3", ok, ld);
    end
  endtask

  task automatic test_held_request();
    fsm_state_out = ST_S;
    snp_req_valid = 1'b1; snp_req_cmd = SNP_INVAL; snp_req_idx = 4'd2;
    step();  // LOAD of the snoop
    snp_req_valid = 1'b0;
    l1_req_valid = 1'b1; l1_req_cmd = WRITE_D; l1_req_idx = 4'd12;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (l1_req_ready !== 1'b0 || snp_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL held_ready_busy%0d: got l1=%b snp=%b expected 0 0", c, l1_req_ready, snp_req_ready);
      end
      if (c == 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_idx !== 4'd2) begin
          failures++;
          $display("FAIL held_first_rsp: got rv=%b src=%b idx=%h expected 1 1 2", rsp_valid, rsp_src, rsp_idx);
        end
      end
      step();
    end
    #1;
    checks++;
    if (l1_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL held_grant: got %b expected 1", l1_req_ready);
    end
    fsm_state_out = ST_M;
    step();  // LOAD
    l1_req_valid = 1'b0;
    step();  // EXEC
    checks++;
    if (fsm_nmsg !== WRITE_D) begin
      failures++;
      $display("FAIL held_cmd: got %h expected 2", fsm_nmsg);
    end
    step();  // WB
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 1'b0 || rsp_idx !== 4'd12 || rsp_state !== ST_M) begin
      failures++;
      $display("FAIL held_rsp: got rv=%b src=%b idx=%h st=%h expected 1 0 c 3",
               rsp_valid, rsp_src, rsp_idx, rsp_state);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok; logic [1:0] ld; bit rv; logic rsrc; logic [3:0] ridx; logic [1:0] rst_o;
    int seen_rsp;
    fsm_state_out = ST_M;
    l1_req_valid = 1'b1; l1_req_cmd = WRITE_D; l1_req_idx = 4'd7;
    step();  // LOAD
    l1_req_valid = 1'b0;
    step();  // EXEC
    checks++;
    if (fsm_valid_d !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_exec: got valid_d=%b expected 1", fsm_valid_d);
    end
    rstb = 1'b0;
    #2;
    checks++;
    if (fsm_nmsg !== IDLE_MSG || busy !== 1'b0 || fsm_valid_d !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_abort: got nmsg=%h busy=%b valid_d=%b expected f 0 0", fsm_nmsg, busy, fsm_valid_d);
    end
    rstb = 1'b1;
    seen_rsp = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (rsp_valid !== 1'b0) seen_rsp++;
    end
    checks++;
    if (seen_rsp !== 0) begin
      failures++;
      $display("FAIL rstmid_no_rsp: got %0d pulses expected 0", seen_rsp);
    end
    issue(1'b0, READ_D, 4'd7, ST_E, ok, ld, rv, rsrc, ridx, rst_o);
    checks++;
    if (!ok || ld !== ST_I || !rv || ridx !== 4'd7) begin
      failures++;
      $display("FAIL rstmid_next: got ok=%b load=%h rv=%b idx=%h expected 1 0 1 7", ok, ld, rv, ridx);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_l1_basic();
    test_snoop_inval();
    test_arbitration();
    test_snoop_only();
    test_index_wrap();
    test_held_request();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
